// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types and helpers for the byte-enable dual-port RAM
package dp_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Even parity: the stored bit makes the byte plus parity an even count of ones.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

  // One byte lane of a byte-enable merge: take the new byte when its enable is set.
  function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old_b,
                                                   input logic [BYTE_W-1:0] new_b,
                                                   input logic              en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dp_ram_if.sv
// rtl/dp_ram_if.sv - write/read request bus and status of the byte-enable dual-port RAM
interface dp_ram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  import dp_ram_pkg::*;

  localparam int BE_W = DATA_WIDTH / BYTE_W;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BE_W-1:0]       wr_be;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  init_busy;
  logic                  rd_parity_err;

  modport master (
    output wr_en, wr_addr, wr_be, data_in, rd_en, rd_addr,
    input  data_out, rd_valid, init_busy, rd_parity_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, data_in, rd_en, rd_addr,
    output data_out, rd_valid, init_busy, rd_parity_err
  );

endinterface

// File: rtl/dp_ram_clear_ctrl.sv
// rtl/dp_ram_clear_ctrl.sv - post-reset array sweep: CLEAR/READY FSM and clear address counter
module dp_ram_clear_ctrl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  // State register and sweep counter; reset always restarts the sweep at address 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + ONE;
      end
    end
  end

  // Leave CLEAR once the last address has been zeroed; READY is terminal until reset.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_addr == LAST_ADDR) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // The array is written with zeros for every cycle spent in CLEAR.
  always_comb begin
    init_busy = (state == CLEAR);
    clr_we    = (state == CLEAR);
  end

endmodule

// File: rtl/dp_ram_be_rtl.sv
// rtl/dp_ram_be_rtl.sv - byte-enable dual-port RAM with forwarding, 1/2-cycle reads, DP_RAM_PARITY_EN parity
module dp_ram_be_rtl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int WR_FWD     = 1
) (
  input  logic     clk_in,
  input  logic     rst_in,
  dp_ram_if.slave  bus
);

  localparam int BE_W  = DATA_WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_data_width
    $error("dp_ram_be_rtl: DATA_WIDTH must be a multiple of 8");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_rd_latency
    $error("dp_ram_be_rtl: RD_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dp_ram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_ctrl (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Requests are dropped (not queued) while clearing or in reset.
  logic accept;
  logic wr_fire;
  logic rd_fire;
  logic collide;

  assign accept  = !init_busy && !rst_in;
  assign wr_fire = bus.wr_en && accept;
  assign rd_fire = bus.rd_en && accept;
  assign collide = (WR_FWD != 0) && wr_fire && rd_fire && (bus.wr_addr == bus.rd_addr);

  logic [DATA_WIDTH-1:0] stored_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [BE_W-1:0]       fwd_lane;
  logic                  rd_err;

  // Read mux: stored word, with same-edge written bytes substituted lane by lane.
  always_comb begin
    stored_word = mem[bus.rd_addr];
    rd_word     = '0;
    fwd_lane    = '0;
    for (int i = 0; i < BE_W; i++) begin
      fwd_lane[i] = collide && bus.wr_be[i];
      rd_word[i*BYTE_W +: BYTE_W] = byte_merge(stored_word[i*BYTE_W +: BYTE_W],
                                               bus.data_in[i*BYTE_W +: BYTE_W],
                                               fwd_lane[i]);
    end
  end

  // Array write: the clear sweep owns the port while busy, then byte-lane writes.
  always_ff @(posedge clk_in) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.data_in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

`ifdef DP_RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] par_calc;
  logic [BE_W-1:0] par_ref;

  // Parity array follows the data array lane for lane; zero data has zero parity.
  always_ff @(posedge clk_in) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.wr_be[i]) begin
          par_mem[bus.wr_addr][i] <= byte_parity(bus.data_in[i*BYTE_W +: BYTE_W]);
        end
      end
    end
  end

  // Forwarded lanes compare against freshly generated parity, so they never flag.
  always_comb begin
    par_calc = '0;
    par_ref  = '0;
    for (int i = 0; i < BE_W; i++) begin
      par_calc[i] = byte_parity(rd_word[i*BYTE_W +: BYTE_W]);
      par_ref[i]  = fwd_lane[i] ? byte_parity(bus.data_in[i*BYTE_W +: BYTE_W])
                                : par_mem[bus.rd_addr][i];
    end
    rd_err = |(par_calc ^ par_ref);
  end
`else
  assign rd_err = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  err_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_err;

    // Two-stage read: capture at the request edge, present one edge later.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        s1_valid <= 1'b0;
        s1_err   <= 1'b0;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
        data_q   <= '0;
      end else begin
        s1_valid <= rd_fire;
        s1_err   <= rd_fire && rd_err;
        if (rd_fire) s1_data <= rd_word;
        valid_q  <= s1_valid;
        err_q    <= s1_err;
        if (s1_valid) data_q <= s1_data;
      end
    end
  end else begin : g_lat1
    // Single-stage read: output register loads at the request edge, holds otherwise.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= rd_fire;
        err_q   <= rd_fire && rd_err;
        if (rd_fire) data_q <= rd_word;
      end
    end
  end

  assign bus.data_out      = data_q;
  assign bus.rd_valid      = valid_q;
  assign bus.rd_parity_err = err_q;
  assign bus.init_busy     = init_busy;

endmodule

// File: tb/tb_dp_ram_be_rtl.sv
// tb/tb_dp_ram_be_rtl.sv - self-checking bench for dp_ram_be_rtl (latency-1/forwarding and latency-2/no-forwarding instances)
module tb_dp_ram_be_rtl;

`ifdef DP_RAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en   = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [3:0]  wr_be   = '0;
  logic [31:0] data_in = '0;
  logic        rd_en   = 1'b0;
  logic [7:0]  rd_addr = '0;

  dp_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_a ();
  dp_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.wr_en = wr_en;   assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_be = wr_be;   assign bus_b.wr_be = wr_be;
  assign bus_a.data_in = data_in; assign bus_b.data_in = data_in;
  assign bus_a.rd_en = rd_en;   assign bus_b.rd_en = rd_en;
  assign bus_a.rd_addr = rd_addr; assign bus_b.rd_addr = rd_addr;

  dp_ram_be_rtl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(1), .WR_FWD(1)) u_dut_a (
    .clk_in(clk), .rst_in(rst), .bus(bus_a));
  dp_ram_be_rtl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(2), .WR_FWD(0)) u_dut_b (
    .clk_in(clk), .rst_in(rst), .bus(bus_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [256];
  logic [3:0]  m_bad [256];
  int          clear_left = 0;
  logic        exp_a_valid = 0, exp_a_perr = 0, exp_b_valid = 0, exp_b_perr = 0;
  logic [31:0] exp_a_data = 0, exp_b_data = 0;
  logic        b_s1_valid = 0, b_s1_perr = 0;
  logic [31:0] b_s1_data = 0;
  logic [31:0] m_old, m_merged;
  logic [3:0]  m_fwd;
  int          flip_cnt = 0, flip_seen = 0;
  logic [7:0]  flip_addr = 8'h30;

  always @(posedge clk) begin
    if (flip_seen != flip_cnt) begin
      m_bad[flip_addr][0] = ~m_bad[flip_addr][0];
      flip_seen = flip_cnt;
    end
    if (rst) begin
      clear_left = 256;
      exp_a_valid = 0; exp_a_perr = 0; exp_a_data = 0;
      exp_b_valid = 0; exp_b_perr = 0; exp_b_data = 0;
      b_s1_valid = 0;  b_s1_perr = 0;
      for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_bad[i] = 0; end
    end else if (clear_left > 0) begin
      clear_left--;
      exp_a_valid = 0; exp_a_perr = 0;
      exp_b_valid = 0; exp_b_perr = 0;
      b_s1_valid = 0;  b_s1_perr = 0;
    end else begin
      m_old = m_mem[rd_addr];
      m_fwd = (wr_en && rd_en && wr_addr == rd_addr) ? wr_be : 4'h0;
      for (int l = 0; l < 4; l++)
        m_merged[l*8 +: 8] = m_fwd[l] ? data_in[l*8 +: 8] : m_old[l*8 +: 8];
      exp_b_valid = b_s1_valid;
      exp_b_perr  = b_s1_perr;
      if (b_s1_valid) exp_b_data = b_s1_data;
      b_s1_valid = rd_en;
      b_s1_data  = m_old;
      b_s1_perr  = rd_en && PAR_ON && (m_bad[rd_addr] != 0);
      exp_a_valid = rd_en;
      if (rd_en) exp_a_data = m_merged;
      exp_a_perr = rd_en && PAR_ON && ((m_bad[rd_addr] & ~m_fwd) != 0);
      if (wr_en)
        for (int l = 0; l < 4; l++)
          if (wr_be[l]) begin
            m_mem[wr_addr][l*8 +: 8] = data_in[l*8 +: 8];
            m_bad[wr_addr][l] = 1'b0;
          end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] last_a_data = 0, last_b_data = 0;
  logic        last_a_perr = 0, last_b_perr = 0;
  int          a_rd_cnt = 0;
  logic [31:0] b_log[$];

  always @(negedge clk) begin
    chk("a_init_busy", 32'(bus_a.init_busy), 32'(clear_left > 0));
    chk("b_init_busy", 32'(bus_b.init_busy), 32'(clear_left > 0));
    chk("a_rd_valid", 32'(bus_a.rd_valid), 32'(exp_a_valid));
    chk("b_rd_valid", 32'(bus_b.rd_valid), 32'(exp_b_valid));
    chk("a_data_out", bus_a.data_out, exp_a_data);
    chk("b_data_out", bus_b.data_out, exp_b_data);
    chk("a_parity_err", 32'(bus_a.rd_parity_err), 32'(exp_a_perr));
    chk("b_parity_err", 32'(bus_b.rd_parity_err), 32'(exp_b_perr));
    if (bus_a.rd_valid) begin
      last_a_data = bus_a.data_out; last_a_perr = bus_a.rd_parity_err; a_rd_cnt++;
    end
    if (bus_b.rd_valid) begin
      last_b_data = bus_b.data_out; last_b_perr = bus_b.rd_parity_err; b_log.push_back(bus_b.data_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_en = 0; rd_en = 0; wr_be = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; data_in = d; wr_be = be; rd_en = 0;
    @(negedge clk); idle();
  endtask

  task automatic rd(input logic [7:0] a);
    rd_en = 1; rd_addr = a; wr_en = 0;
    @(negedge clk); idle();
  endtask

  task automatic wrrd(input logic [7:0] wa, input logic [31:0] d, input logic [3:0] be, input logic [7:0] ra);
    wr_en = 1; wr_addr = wa; data_in = d; wr_be = be; rd_en = 1; rd_addr = ra;
    @(negedge clk); idle();
  endtask

  // Let both instances complete, then look at the captured results off the edge.
  task automatic drain();
    cyc(2); #2;
  endtask

  // Called on the first falling edge after a reset edge: pokes requests that must be
  // dropped, then counts the cycles init_busy stays high (bounded).
  task automatic clear_phase();
    int busy_cnt;
    busy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1; wr_addr = 8'h05; data_in = 32'hFFFF_FFFF; wr_be = 4'hF;
      rd_en = 1; rd_addr = 8'h05;
      @(negedge clk); busy_cnt++;
    end
    idle();
    while (bus_a.init_busy && busy_cnt < 400) begin
      @(negedge clk); busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd256);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] vec_addr [6] = '{32'hFF, 32'hFF, 32'h00, 32'h7E, 32'h7E, 32'h7F};
  logic [31:0] vec_data [6] = '{32'h0102_0304, 32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222, 32'h0BAD_BEEF};
  logic [3:0]  vec_be   [6] = '{4'b1000, 4'b0110, 4'b1111, 4'b1111, 4'b1001, 4'b0000};

  initial begin : stim
    int base;
    rst = 1; idle();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 256; i++) begin
      u_dut_a.mem[i] = $urandom; u_dut_b.mem[i] = $urandom;
`ifdef DP_RAM_PARITY_EN
      u_dut_a.par_mem[i] = 4'($urandom); u_dut_b.par_mem[i] = 4'($urandom);
`endif
    end
    clear_phase();

    rd(8'h00); drain();
    chk("t1_rd00_a", last_a_data, 32'h0);
    rd(8'hFF); drain();
    chk("t1_rdff_a", last_a_data, 32'h0);
    chk("t1_rdff_b", last_b_data, 32'h0);
    chk("t1_read_count", 32'(a_rd_cnt), 32'd2);

    wr(8'h10, 32'hAABB_CCDD, 4'b1111);
    wr(8'h10, 32'h1122_3344, 4'b0101);
    rd(8'h10); drain();
    chk("t2_merge_a", last_a_data, 32'hAA22_CC44);
    chk("t2_merge_b", last_b_data, 32'hAA22_CC44);
    wr(8'h10, 32'h0, 4'b0000);
    rd(8'h10); drain();
    chk("t2_be0_noop_a", last_a_data, 32'hAA22_CC44);

    wrrd(8'h20, 32'hFFFF_FFFF, 4'b0011, 8'h20); drain();
    chk("t3_fwd_a", last_a_data, 32'h0000_FFFF);
    chk("t3_nofwd_b", last_b_data, 32'h0000_0000);
    rd(8'h20); drain();
    chk("t3_later_a", last_a_data, 32'h0000_FFFF);
    chk("t3_later_b", last_b_data, 32'h0000_FFFF);

    for (int i = 0; i < 4; i++) wr(8'(i), 32'hA0 + 32'(i), 4'hF);
    base = b_log.size();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_addr = 8'(i); @(negedge clk);
    end
    idle(); drain();
    chk("t4_b_count", 32'(b_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < b_log.size()) chk("t4_b_order", b_log[base + i], 32'hA0 + 32'(i));

    for (int i = 0; i < 6; i++) wr(8'(vec_addr[i]), vec_data[i], vec_be[i]);
    wrrd(8'h7E, 32'h3344_5566, 4'b0100, 8'h7F);
    wr(8'h40, 32'h600D_F00D, 4'hF);
    rd(8'h40);
    rd(8'hFF); rd(8'h7E); rd(8'h7F); rd(8'h00); drain();
    chk("vec_00_a", last_a_data, 32'hCAFE_F00D);

    wr(8'h05, 32'hDEAD_BEEF, 4'hF);
    rst = 1; @(negedge clk); rst = 0;
    cyc(100);
    rst = 1; wr_en = 1; wr_addr = 8'h05; data_in = 32'h1234_5678; wr_be = 4'hF;
    @(negedge clk);
    rst = 0; idle();
    clear_phase();
    rd(8'h05); drain();
    chk("t5_rd05_a", last_a_data, 32'h0);
    chk("t5_rd05_b", last_b_data, 32'h0);

    wr(8'h30, 32'h1234_5678, 4'hF);
    wr(8'h31, 32'h0F0F_0F0F, 4'hF);
`ifdef DP_RAM_PARITY_EN
    u_dut_a.par_mem[8'h30][0] = ~u_dut_a.par_mem[8'h30][0];
    u_dut_b.par_mem[8'h30][0] = ~u_dut_b.par_mem[8'h30][0];
    flip_cnt++;
    rd(8'h30); drain();
    chk("t6_flip_a", 32'(last_a_perr), 32'd1);
    chk("t6_flip_b", 32'(last_b_perr), 32'd1);
    rd(8'h31); drain();
    chk("t6_clean_a", 32'(last_a_perr), 32'd0);
    wrrd(8'h30, 32'h0000_00AA, 4'b0001, 8'h30); drain();
    chk("t6_fwd_a", 32'(last_a_perr), 32'd0);
    chk("t6_fwd_b", 32'(last_b_perr), 32'd1);
    chk("t6_fwd_data_a", last_a_data, 32'h1234_56AA);
    rd(8'h30); drain();
    chk("t6_rewritten_a", 32'(last_a_perr), 32'd0);
`else
    rd(8'h30); drain();
    chk("t6_noparity_a", 32'(last_a_perr), 32'd0);
    chk("t6_noparity_b", 32'(last_b_perr), 32'd0);
`endif
    chk("t6_data_a", last_a_data, PAR_ON ? 32'h1234_56AA : 32'h1234_5678);

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
